// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared types and constants for the keyboard direction path:
//                direction enum, prefix-decoder state enum, PS/2 set-2
//                scan-code constants and a small direction helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Encoding is chosen so that opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Prefix decoder states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kd_state_t;

    // Prefix bytes and plain keys.
    localparam logic [7:0] c_sc_ext      = 8'hE0;
    localparam logic [7:0] c_sc_brk      = 8'hF0;
    localparam logic [7:0] c_sc_space    = 8'h29;

    // Arrow keys (valid only after the E0 prefix).
    localparam logic [7:0] c_sc_arr_up   = 8'h75;
    localparam logic [7:0] c_sc_arr_down = 8'h72;
    localparam logic [7:0] c_sc_arr_left = 8'h6B;
    localparam logic [7:0] c_sc_arr_rght = 8'h74;

    // WASD keys (unprefixed).
    localparam logic [7:0] c_sc_w        = 8'h1D;
    localparam logic [7:0] c_sc_s        = 8'h1B;
    localparam logic [7:0] c_sc_a        = 8'h1C;
    localparam logic [7:0] c_sc_d        = 8'h23;

    // Opposite direction: flip bit 0 (UP<->DOWN, LEFT<->RIGHT).
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/scan_lut.sv
`default_nettype none
// ============================================================================
//  Module      : scan_lut
//  Description : Combinational scan-code to direction-request lookup.
//                Extended (E0-prefixed) arrow codes always map; WASD codes
//                map only when they arrive unprefixed and KEY_WASD_EN is
//                defined.
//  Ports       : i_code      - scan-code byte
//                i_ext       - byte follows an E0 prefix
//                o_req_valid - byte is a direction key
//                o_req_dir   - requested direction (UP when not valid)
//  Config      : KEY_WASD_EN - enables the unprefixed WASD mapping
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_lut
    import snake_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_ext,
    output logic       o_req_valid,
    output dir_t       o_req_dir
);

    always_comb begin
        o_req_valid = 1'b0;
        o_req_dir   = UP;
        if (i_ext) begin
            case (i_code)
                c_sc_arr_up:   begin o_req_valid = 1'b1; o_req_dir = UP;    end
                c_sc_arr_down: begin o_req_valid = 1'b1; o_req_dir = DOWN;  end
                c_sc_arr_left: begin o_req_valid = 1'b1; o_req_dir = LEFT;  end
                c_sc_arr_rght: begin o_req_valid = 1'b1; o_req_dir = RIGHT; end
                default:       begin o_req_valid = 1'b0; o_req_dir = UP;    end
            endcase
        end else begin
`ifdef KEY_WASD_EN
            case (i_code)
                c_sc_w:  begin o_req_valid = 1'b1; o_req_dir = UP;    end
                c_sc_s:  begin o_req_valid = 1'b1; o_req_dir = DOWN;  end
                c_sc_a:  begin o_req_valid = 1'b1; o_req_dir = LEFT;  end
                c_sc_d:  begin o_req_valid = 1'b1; o_req_dir = RIGHT; end
                default: begin o_req_valid = 1'b0; o_req_dir = UP;    end
            endcase
`else
            o_req_valid = 1'b0;
            o_req_dir   = UP;
`endif
        end
    end

endmodule : scan_lut
`default_nettype wire

// File: rtl/key_direction.sv
`default_nettype none
// ============================================================================
//  Module      : key_direction
//  Description : Decodes PS/2 set-2 scan-code bytes into a steering direction
//                and a pause toggle. A four-state prefix decoder tracks E0/F0
//                prefixes; break sequences are swallowed. A pending prefix is
//                abandoned after PREFIX_TMO cycles without a new byte.
//  Ports       : CLK        - system clock, rising edge
//                RESET      - asynchronous active-high reset
//                code       - scan-code byte, synchronous to CLK
//                code_valid - single-cycle strobe qualifying code
//                dir        - current direction (0 UP,1 DOWN,2 LEFT,3 RIGHT)
//                dir_chg    - single-cycle pulse when dir changes
//                paused     - pause flag, toggled by the space make code
//  Params      : START_DIR  - direction after reset
//                PREFIX_TMO - prefix lifetime in CLK cycles
//  Config      : KEY_WASD_EN - also steer with unprefixed W/A/S/D
//  Revision    : 1.0 - initial release
// ============================================================================
module key_direction
    import snake_pkg::*;
#(
    parameter logic [1:0] START_DIR  = 2'd3,
    parameter int         PREFIX_TMO = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [1:0] dir,
    output logic       dir_chg,
    output logic       paused
);

    localparam int                 c_cnt_w   = $clog2(PREFIX_TMO + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(PREFIX_TMO - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    kd_state_t          r_state;
    kd_state_t          w_state_nxt;
    dir_t               r_dir;
    logic               r_dir_chg;
    logic               r_paused;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_lut_ext;
    logic               w_lut_valid;
    dir_t               w_lut_dir;
    logic               w_req_en;
    logic               w_accept;
    logic               w_pause_tgl;
    logic               w_timeout;

    // The lookup sees the byte as extended only when it directly follows E0.
    assign w_lut_ext = (r_state == ST_EXT);

    scan_lut u_scan_lut (
        .i_code      (code),
        .i_ext       (w_lut_ext),
        .o_req_valid (w_lut_valid),
        .o_req_dir   (w_lut_dir)
    );

    // A pending prefix expires once the idle counter reaches its limit; a byte
    // arriving in that same cycle wins because code_valid is tested first.
    assign w_timeout = (r_state != ST_IDLE) && (r_cnt >= c_cnt_lim);

    // ------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_en    = 1'b0;
        w_pause_tgl = 1'b0;
        if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code == c_sc_ext) begin
                        w_state_nxt = ST_EXT;
                    end else if (code == c_sc_brk) begin
                        w_state_nxt = ST_BRK;
                    end else if (code == c_sc_space) begin
                        w_pause_tgl = 1'b1;
                    end else begin
                        // Only WASD can hit here, and only when enabled.
                        w_req_en = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (code == c_sc_brk) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (code == c_sc_ext) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_req_en    = 1'b1;
                    end
                end
                // The byte after a break prefix is the released key: drop it.
                ST_BRK:     w_state_nxt = ST_IDLE;
                ST_EXT_BRK: w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Reversing or re-requesting the current heading is not a change.
    assign w_accept = w_req_en && w_lut_valid &&
                      (w_lut_dir != r_dir) &&
                      (w_lut_dir != opposite_dir(r_dir));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_dir     <= dir_t'(START_DIR);
            r_dir_chg <= 1'b0;
            r_paused  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_chg <= w_accept;
            if (w_accept) begin
                r_dir <= w_lut_dir;
            end
            if (w_pause_tgl) begin
                r_paused <= ~r_paused;
            end
            // Idle-cycle counter: cleared by any byte, saturates otherwise.
            if (code_valid) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign dir     = r_dir;
    assign dir_chg = r_dir_chg;
    assign paused  = r_paused;

endmodule : key_direction
`default_nettype wire

// File: tb/tb_key_direction.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_direction
//  Description : Self-checking bench for key_direction. Stimulus pushes the
//                hand-computed expected {dir, dir_chg, paused} for the cycle
//                after each byte into a scoreboard; a monitor process pops
//                and compares. Expectations follow KEY_WASD_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_direction;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code;
    logic       code_valid;
    logic [1:0] dir;
    logic       dir_chg;
    logic       paused;

    always #5 clk = ~clk;

    key_direction #(
        .START_DIR  (2'd3),
        .PREFIX_TMO (16)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .code       (code),
        .code_valid (code_valid),
        .dir        (dir),
        .dir_chg    (dir_chg),
        .paused     (paused)
    );

    typedef struct {
        int         cyc;
        int         step;
        logic [7:0] code;
        logic [1:0] dir;
        logic       chg;
        logic       pau;
    } exp_t;

    exp_t sb[$];
    exp_t sb_now[$];
    event chk_ev;
    int   cyc    = 0;
    int   step   = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input exp_t e);
        checks++;
        if ({dir, dir_chg, paused} !== {e.dir, e.chg, e.pau}) begin
            errors++;
            $display("FAIL step%0d code %h: got dir=%0d dir_chg=%0b paused=%0b, want dir=%0d dir_chg=%0b paused=%0b",
                     e.step, e.code, dir, dir_chg, paused, e.dir, e.chg, e.pau);
        end
    endtask

    // Monitor: sole owner of the check/error counters.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_now.size() > 0) begin
                e = sb_now.pop_front();
                compare(e);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL step%0d stale: checked at cycle %0d, want cycle %0d", e.step, cyc, e.cyc);
                end else begin
                    compare(e);
                end
            end
        end
    end

    // Drive one byte at a negedge; expectation applies one cycle later.
    task automatic send(input logic [7:0] c, input logic [1:0] d,
                        input logic ch, input logic p);
        exp_t e;
        code       = c;
        code_valid = 1'b1;
        step++;
        e.cyc = cyc + 1; e.step = step; e.code = c;
        e.dir = d; e.chg = ch; e.pau = p;
        sb.push_back(e);
        @(negedge clk);
        code_valid = 1'b0;
        code       = 8'hF0;   // garbage while not valid
    endtask

    task automatic expect_next(input logic [1:0] d, input logic ch, input logic p);
        exp_t e;
        step++;
        e.cyc = cyc + 1; e.step = step; e.code = 8'h00;
        e.dir = d; e.chg = ch; e.pau = p;
        sb.push_back(e);
    endtask

    task automatic check_now(input logic [1:0] d, input logic ch, input logic p);
        exp_t e;
        step++;
        e.cyc = cyc; e.step = step; e.code = 8'h00;
        e.dir = d; e.chg = ch; e.pau = p;
        sb_now.push_back(e);
        -> chk_ev;
        #1;
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 200000", $time);
        $fatal(1);
    end

    initial begin : p_stim
        rst        = 1'b1;
        code       = 8'h00;
        code_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_now(2'd3, 1'b0, 1'b0);
        rst = 1'b0;
        expect_next(2'd3, 1'b0, 1'b0);
        @(negedge clk);

        // Arrow UP from RIGHT
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h75, 2'd0, 1'b1, 1'b0);
        // Back to RIGHT, then reverse and same-direction requests ignored
        send(8'hE0, 2'd0, 1'b0, 1'b0);
        send(8'h74, 2'd3, 1'b1, 1'b0);
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h6B, 2'd3, 1'b0, 1'b0);
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h74, 2'd3, 1'b0, 1'b0);

        // DOWN, then extended break, pause toggles, plain break of space
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h72, 2'd1, 1'b1, 1'b0);
        send(8'hE0, 2'd1, 1'b0, 1'b0);
        send(8'hF0, 2'd1, 1'b0, 1'b0);
        send(8'h72, 2'd1, 1'b0, 1'b0);
        send(8'h29, 2'd1, 1'b0, 1'b1);
        send(8'hF0, 2'd1, 1'b0, 1'b1);
        send(8'h29, 2'd1, 1'b0, 1'b1);
        // Repeated E0 stays extended; request accepted while paused
        send(8'hE0, 2'd1, 1'b0, 1'b1);
        send(8'hE0, 2'd1, 1'b0, 1'b1);
        send(8'h6B, 2'd2, 1'b1, 1'b1);
        send(8'h29, 2'd2, 1'b0, 1'b0);

        // Unknown extended code returns to IDLE; unprefixed arrow ignored
        send(8'hE0, 2'd2, 1'b0, 1'b0);
        send(8'h12, 2'd2, 1'b0, 1'b0);
        send(8'h75, 2'd2, 1'b0, 1'b0);
        send(8'h72, 2'd2, 1'b0, 1'b0);

        // Prefix timeout boundary (PREFIX_TMO = 16)
        send(8'hE0, 2'd2, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        send(8'h72, 2'd1, 1'b1, 1'b0);      // last surviving cycle
        send(8'hE0, 2'd1, 1'b0, 1'b0);
        send(8'h6B, 2'd2, 1'b1, 1'b0);
        send(8'hE0, 2'd2, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        send(8'h75, 2'd2, 1'b0, 1'b0);      // prefix expired
        send(8'hE0, 2'd2, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        send(8'h72, 2'd2, 1'b0, 1'b0);

        // WASD (via UP to reach RIGHT)
        send(8'hE0, 2'd2, 1'b0, 1'b0);
        send(8'h75, 2'd0, 1'b1, 1'b0);
        send(8'hE0, 2'd0, 1'b0, 1'b0);
        send(8'h74, 2'd3, 1'b1, 1'b0);
`ifdef KEY_WASD_EN
        send(8'h1D, 2'd0, 1'b1, 1'b0);
        send(8'hE0, 2'd0, 1'b0, 1'b0);
        send(8'h23, 2'd0, 1'b0, 1'b0);      // E0-prefixed D is not a key
        send(8'h23, 2'd3, 1'b1, 1'b0);
        send(8'h1C, 2'd3, 1'b0, 1'b0);
`else
        send(8'h1D, 2'd3, 1'b0, 1'b0);
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h23, 2'd3, 1'b0, 1'b0);
        send(8'h23, 2'd3, 1'b0, 1'b0);
        send(8'h1C, 2'd3, 1'b0, 1'b0);
`endif

        // Asynchronous reset between E0 and 75
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h75, 2'd0, 1'b1, 1'b0);
        send(8'h29, 2'd0, 1'b0, 1'b1);
        send(8'hE0, 2'd0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_now(2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h75, 2'd3, 1'b0, 1'b0);
        send(8'hE0, 2'd3, 1'b0, 1'b0);
        send(8'h72, 2'd1, 1'b1, 1'b0);
        expect_next(2'd1, 1'b0, 1'b0);      // dir_chg lasts one cycle
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_direction
`default_nettype wire
